// File: rtl/dequantizer_stream.sv
// Streaming JPEG dequantizer: 64-coefficient blocks, run-time loadable quant tables,
// two-stage valid/ready pipeline with saturating signed multiply.
module dequantizer_stream #(
    parameter int unsigned COEF_W     = 12,
    parameter int unsigned Q_W        = 8,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned NUM_TABLES = 2,
    parameter int unsigned TSEL_W     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tbl_wr_en,
    input  logic [TSEL_W-1:0] tbl_wr_sel,
    input  logic [5:0]        tbl_wr_addr,
    input  logic [Q_W-1:0]    tbl_wr_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [COEF_W-1:0] s_coef,
    input  logic [TSEL_W-1:0] s_tsel,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [OUT_W-1:0]  m_coef,
    output logic [5:0]        m_idx,
    output logic              m_last,
    output logic              m_sat,
    output logic [15:0]       blk_cnt
);

    localparam int unsigned PW = COEF_W + Q_W + 1;
    localparam int unsigned EW = ((PW > OUT_W) ? PW : OUT_W) + 1;
    localparam logic [TSEL_W:0] NUM_T = (TSEL_W + 1)'(NUM_TABLES);
    localparam logic signed [EW-1:0] MAX_V = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {{(EW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic [Q_W-1:0]           r_tbl [NUM_TABLES][64];
    logic [5:0]               r_in_idx;
    logic [TSEL_W-1:0]        r_tsel;
    logic                     r_s1_valid;
    logic signed [COEF_W-1:0] r_s1_coef;
    logic [5:0]               r_s1_idx;
    logic [Q_W-1:0]           r_s1_q;
    logic                     r_m_valid;
    logic [OUT_W-1:0]         r_m_coef;
    logic [5:0]               r_m_idx;
    logic                     r_m_last;
    logic                     r_m_sat;
    logic [15:0]              r_blk_cnt;

    logic                     w_en;
    logic                     w_in_xfer;
    logic                     w_wr_ok;
    logic [TSEL_W-1:0]        w_tsel_req;
    logic [TSEL_W-1:0]        w_tsel;
    logic [Q_W-1:0]           w_q;
    logic signed [PW-1:0]     w_coef_x;
    logic signed [PW-1:0]     w_q_x;
    logic signed [PW-1:0]     w_prod;
    logic signed [EW-1:0]     w_prod_x;
    logic [OUT_W-1:0]         w_res;
    logic                     w_sat;

    assign w_en      = !r_m_valid || m_ready;
    assign s_ready   = w_en;
    assign w_in_xfer = s_valid && w_en;
    assign w_wr_ok   = tbl_wr_en && ({1'b0, tbl_wr_sel} < NUM_T);

    // Select is taken live on index 0, then held for the rest of the block.
    assign w_tsel_req = (r_in_idx == 6'd0) ? s_tsel : r_tsel;
    assign w_tsel     = ({1'b0, w_tsel_req} < NUM_T) ? w_tsel_req : '0;
    assign w_q        = r_tbl[w_tsel][r_in_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < int'(NUM_TABLES); t++) begin
                for (int a = 0; a < 64; a++) begin
                    r_tbl[t][a] <= Q_W'(1);
                end
            end
        end else if (w_wr_ok) begin
            r_tbl[tbl_wr_sel][tbl_wr_addr] <= tbl_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_idx <= '0;
            r_tsel   <= '0;
        end else if (w_in_xfer) begin
            r_in_idx <= r_in_idx + 6'd1;
            if (r_in_idx == 6'd0) begin
                r_tsel <= w_tsel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_coef  <= '0;
            r_s1_idx   <= '0;
            r_s1_q     <= '0;
        end else if (w_en) begin
            r_s1_valid <= s_valid;
            if (s_valid) begin
                r_s1_coef <= s_coef;
                r_s1_idx  <= r_in_idx;
                r_s1_q    <= w_q;
            end
        end
    end

    assign w_coef_x = {{(PW - COEF_W){r_s1_coef[COEF_W-1]}}, r_s1_coef};
    assign w_q_x    = {{(PW - Q_W){1'b0}}, r_s1_q};
    assign w_prod   = w_coef_x * w_q_x;
    assign w_prod_x = {{(EW - PW){w_prod[PW-1]}}, w_prod};

    always_comb begin
        w_res = w_prod_x[OUT_W-1:0];
        w_sat = 1'b0;
        if (w_prod_x > MAX_V) begin
            w_res = {1'b0, {(OUT_W - 1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_prod_x < MIN_V) begin
            w_res = {1'b1, {(OUT_W - 1){1'b0}}};
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_coef  <= '0;
            r_m_idx   <= '0;
            r_m_last  <= 1'b0;
            r_m_sat   <= 1'b0;
        end else if (w_en) begin
            r_m_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_m_coef <= w_res;
                r_m_idx  <= r_s1_idx;
                r_m_last <= (r_s1_idx == 6'd63);
                r_m_sat  <= w_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (r_m_valid && m_ready && r_m_last) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign m_valid = r_m_valid;
    assign m_coef  = r_m_coef;
    assign m_idx   = r_m_idx;
    assign m_last  = r_m_last;
    assign m_sat   = r_m_sat;
    assign blk_cnt = r_blk_cnt;

endmodule

// File: tb/tb_dequantizer_stream.sv
// Scoreboard bench for dequantizer_stream: a table/arithmetic reference model predicts every
// output; a negedge monitor checks outputs, handshake, stall stability and reset behaviour.
module tb_dequantizer_stream;

    localparam int COEF_W     = 12;
    localparam int Q_W        = 8;
    localparam int OUT_W      = 16;
    localparam int NUM_TABLES = 2;
    localparam int TSEL_W     = 1;
    localparam int OMAX       = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN       = -(1 << (OUT_W - 1));

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              tbl_wr_en = 1'b0;
    logic [TSEL_W-1:0] tbl_wr_sel = '0;
    logic [5:0]        tbl_wr_addr = '0;
    logic [Q_W-1:0]    tbl_wr_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [COEF_W-1:0] s_coef = '0;
    logic [TSEL_W-1:0] s_tsel = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [OUT_W-1:0]  m_coef;
    logic [5:0]        m_idx;
    logic              m_last;
    logic              m_sat;
    logic [15:0]       blk_cnt;

    dequantizer_stream #(
        .COEF_W    (COEF_W),
        .Q_W       (Q_W),
        .OUT_W     (OUT_W),
        .NUM_TABLES(NUM_TABLES),
        .TSEL_W    (TSEL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_wr_en  (tbl_wr_en),
        .tbl_wr_sel (tbl_wr_sel),
        .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_data(tbl_wr_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_coef     (s_coef),
        .s_tsel     (s_tsel),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_coef     (m_coef),
        .m_idx      (m_idx),
        .m_last     (m_last),
        .m_sat      (m_sat),
        .blk_cnt    (blk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int coef;
        int idx;
        int last;
        int sat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Stimulus knobs, written only by the main process.
    int   ready_mode = 0;      // 0: always ready, 1: random
    int   stall_from = 1 << 30;
    bit   wr_rand = 1'b0;
    bit   bubbles = 1'b0;
    int   rcyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready generator, with a 5-cycle forced stall window.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            if (rcyc >= stall_from && rcyc < stall_from + 5) m_ready = 1'b0;
            else if (ready_mode == 1) m_ready = 1'($urandom_range(0, 1));
            else m_ready = 1'b1;
        end
    end

    // Monitor: reference model, scoreboard push on accept, pop/compare on output transfer.
    initial begin
        int   mtbl[NUM_TABLES][64];
        int   acc_cnt;
        int   blk_tsel;
        int   blocks;
        int   cyc;
        int   first_acc_cyc;
        bit   first_acc_seen;
        bit   first_out_seen;
        bit   stall_prev;
        int   saved_idx;
        int   saved_coef;
        exp_t e;
        acc_cnt = 0; blk_tsel = 0; blocks = 0; cyc = 0; first_acc_cyc = 0;
        first_acc_seen = 0; first_out_seen = 0; stall_prev = 0; saved_idx = 0; saved_coef = 0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                chk("rst_m_valid", int'(m_valid), 0);
                chk("rst_m_coef", int'(m_coef), 0);
                chk("rst_m_idx", int'(m_idx), 0);
                chk("rst_m_last", int'(m_last), 0);
                chk("rst_m_sat", int'(m_sat), 0);
                chk("rst_blk_cnt", int'(blk_cnt), 0);
                for (int t = 0; t < NUM_TABLES; t++)
                    for (int a = 0; a < 64; a++) mtbl[t][a] = 1;
                sb.delete();
                acc_cnt = 0; blk_tsel = 0; blocks = 0;
                first_acc_seen = 0; first_out_seen = 0; stall_prev = 0;
            end else begin
                cyc++;
                chk("s_ready", int'(s_ready), int'(!m_valid || m_ready));
                if (stall_prev) begin
                    chk("stall_m_valid", int'(m_valid), 1);
                    chk("stall_m_idx", int'(m_idx), saved_idx);
                    chk("stall_m_coef", int'($signed(m_coef)), saved_coef);
                end
                stall_prev = 1'b0;
                if (m_valid) begin
                    if (!first_out_seen) begin
                        first_out_seen = 1'b1;
                        if (first_acc_seen) chk("latency", cyc - first_acc_cyc, 2);
                    end
                    if (m_ready) begin
                        if (sb.size() == 0) begin
                            chk("spurious_output", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("m_coef", int'($signed(m_coef)), e.coef);
                            chk("m_idx", int'(m_idx), e.idx);
                            chk("m_last", int'(m_last), e.last);
                            chk("m_sat", int'(m_sat), e.sat);
                            chk("blk_cnt", int'(blk_cnt), blocks);
                            if (e.last != 0) blocks = (blocks + 1) % 65536;
                        end
                    end else begin
                        stall_prev = 1'b1;
                        saved_idx  = int'(m_idx);
                        saved_coef = int'($signed(m_coef));
                    end
                end
                if (s_valid && s_ready) begin
                    int idx, c, q, p;
                    idx = acc_cnt % 64;
                    if (idx == 0) blk_tsel = (int'(s_tsel) < NUM_TABLES) ? int'(s_tsel) : 0;
                    c = int'($signed(s_coef));
                    q = mtbl[blk_tsel][idx];
                    p = c * q;
                    e.idx  = idx;
                    e.last = (idx == 63) ? 1 : 0;
                    if (p > OMAX) begin e.coef = OMAX; e.sat = 1; end
                    else if (p < OMIN) begin e.coef = OMIN; e.sat = 1; end
                    else begin e.coef = p; e.sat = 0; end
                    sb.push_back(e);
                    acc_cnt++;
                    if (!first_acc_seen) begin
                        first_acc_seen = 1'b1;
                        first_acc_cyc  = cyc;
                    end
                end
                // Write lands after this edge's lookup, so apply it after the model lookup.
                if (tbl_wr_en && int'(tbl_wr_sel) < NUM_TABLES)
                    mtbl[tbl_wr_sel][tbl_wr_addr] = int'(tbl_wr_data);
            end
        end
    end

    task automatic send(input int c, input int t);
        bit ok;
        int n;
        n = 0;
        s_valid = 1'b1;
        s_coef  = COEF_W'(c);
        s_tsel  = TSEL_W'(t);
        do begin
            if (wr_rand && $urandom_range(0, 2) == 0) begin
                tbl_wr_en   = 1'b1;
                tbl_wr_sel  = TSEL_W'($urandom_range(0, NUM_TABLES - 1));
                tbl_wr_addr = 6'($urandom_range(0, 63));
                tbl_wr_data = Q_W'($urandom_range(0, 255));
            end else begin
                tbl_wr_en = 1'b0;
            end
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                $display("FAIL send_timeout: s_ready stuck low, got 0, expected 1");
                $fatal(1);
            end
        end while (!ok);
        s_valid   = 1'b0;
        tbl_wr_en = 1'b0;
        if (bubbles && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic twrite(input int sel, input int addr, input int data);
        tbl_wr_en   = 1'b1;
        tbl_wr_sel  = TSEL_W'(sel);
        tbl_wr_addr = 6'(addr);
        tbl_wr_data = Q_W'(data);
        @(posedge clk);
        #1;
        tbl_wr_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            $display("FAIL drain_timeout: %0d outputs outstanding, expected 0", sb.size());
            $fatal(1);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int rnd_coef();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Identity tables: +3 in, +3 out for a whole block.
        for (int i = 0; i < 64; i++) send(3, 0);
        drain();

        // Table 1 entry 5 = 16, coefficient -7 at index 5.
        twrite(1, 5, 16);
        for (int i = 0; i < 64; i++) send((i == 5) ? -7 : rnd_coef(), (i == 0) ? 1 : 0);
        drain();

        // Saturation both ways through table0[0] = 255.
        twrite(0, 0, 255);
        for (int i = 0; i < 64; i++) send((i == 0) ? 2047 : rnd_coef(), 0);
        for (int i = 0; i < 64; i++) send((i == 0) ? -2048 : rnd_coef(), 0);
        drain();

        // Mid-block downstream stall with the input still offered.
        for (int i = 0; i < 64; i++) begin
            if (i == 20) stall_from = rcyc + 1;
            send(rnd_coef(), 0);
        end
        drain();
        stall_from = 1 << 30;

        // Distinct table 1, then a select change mid-block.
        for (int a = 0; a < 64; a++) twrite(1, a, int'($urandom_range(2, 255)));
        for (int i = 0; i < 64; i++) send(rnd_coef(), (i < 10) ? 0 : 1);
        for (int i = 0; i < 64; i++) send(rnd_coef(), (i < 10) ? 1 : 0);
        drain();

        // Randomised traffic: bubbles, back-pressure, concurrent table writes.
        ready_mode = 1;
        wr_rand    = 1'b1;
        bubbles    = 1'b1;
        for (int i = 0; i < 4 * 64; i++) send(rnd_coef(), int'($urandom_range(0, 1)));
        drain();

        // Reset at index 30 with the pipeline full.
        ready_mode = 0;
        wr_rand    = 1'b0;
        bubbles    = 1'b0;
        for (int i = 0; i < 30; i++) send(rnd_coef(), 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 64; i++) send(rnd_coef(), int'($urandom_range(0, 1)));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
